mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: width of all memory addresses.
REQ-002 SHALL have parameter DATA_W, default 64: width of memory data words.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: copy request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1: cancel the active copy.
REQ-007 SHALL have port src_adr  input  ADDR_W: first source word address.
REQ-008 SHALL have port dst_adr  input  ADDR_W: first destination word address.
REQ-009 SHALL have port len  input  9: number of words to copy, 0..256.
REQ-010 SHALL have port busy  output  1: high in READ or WRITE.
REQ-011 SHALL have port done  output  1: one-cycle completion pulse.
REQ-012 SHALL have port err  output  1: valid with done; high when the copy was aborted.
REQ-013 SHALL have port words_done  output  9: words written in the current or last copy.
REQ-014 SHALL have port mem_adr  output  ADDR_W: data memory address.
REQ-015 SHALL have port mem_datain  output  DATA_W: data memory write data.
REQ-016 SHALL have port mem_w  output  1: data memory write enable; the memory writes on the rising edge.
REQ-017 SHALL have port mem_r  output  1: data memory read enable; the memory returns read data combinationally.
REQ-018 SHALL have port mem_dataout  input  DATA_W: data memory read data, valid while mem_r=1.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-020 In IDLE, start=1 with len!=0 SHALL latch src_adr, dst_adr and len, clear the index and words_done, and enter READ.
REQ-021 In IDLE, start=1 with len=0 SHALL enter DONE without any memory access.
REQ-022 Start SHALL be ignored in READ, WRITE and DONE.
REQ-023 READ SHALL drive mem_r=1, mem_w=0 and mem_adr=src+index, capture mem_dataout into the data buffer at the clock edge, then enter WRITE.
REQ-024 WRITE SHALL drive mem_w=1, mem_r=0, mem_adr=dst+index and mem_datain=buffer, increment index and words_done, then enter DONE if index+1==len, else READ.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then enter IDLE.
REQ-026 Latency SHALL be exactly 2*len+1 cycles from the start edge to the done cycle (len=0: 1 cycle).
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W, so wrap-around is silent.
REQ-028 The copy SHALL run strictly ascending, one word per READ/WRITE pair; overlapping regions are copied forward without special handling.
REQ-029 mem_r and mem_w SHALL never be 1 in the same cycle.
REQ-030 Outside READ and WRITE, mem_r, mem_w, mem_adr and mem_datain SHALL all be 0.
REQ-031 abort=1 sampled in READ SHALL enter DONE with no write for that word.
REQ-032 abort=1 sampled in WRITE SHALL complete that write (counted) and then enter DONE.
REQ-033 On an abort, err SHALL be 1 in the DONE cycle; err SHALL otherwise be 0.
REQ-034 When abort and the final word's WRITE coincide, the copy SHALL be treated as complete with err=0.
REQ-035 words_done SHALL hold its value after DONE until the next accepted start.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE and set busy, done, err, mem_r and mem_w to 0, mem_adr, mem_datain and words_done to 0, and the buffer and index to 0.
REQ-037 Reset during WRITE SHALL deassert mem_w asynchronously, before the next clock edge; no done pulse SHALL follow.

Verification
REQ-038 Memory preloaded with M[16..19]=A,B,C,D; start with src=16, dst=64, len=4 -> M[64..67]=A,B,C,D; done in cycle 9; words_done=4; err=0.
REQ-039 start with len=0 -> done the next cycle, mem_r and mem_w never asserted, words_done=0.
REQ-040 src=10, dst=11, len=3 with M[10]=X -> M[11..13]=X,X,X (forward overlap).
REQ-041 src=2^64-1, dst=0x100, len=2 -> second read at address 0, no error.
REQ-042 abort in the second READ of a len=5 copy -> one word written, done with err=1, words_done=1.
REQ-043 rst_n=0 mid-WRITE -> mem_w=0 immediately; the next start is accepted normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Copies len words from a source region to a destination region of a single
// data memory, one word at a time: a READ cycle fetches src+index into an
// internal buffer, and the following WRITE cycle stores that buffer at
// dst+index. A one-cycle DONE pulse ends every accepted request. An abort ends
// the copy early and is reported through err in the DONE cycle.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   copy request, only looked at in IDLE
//   abort        in   cancel the active copy (READ or WRITE)
//   src_adr      in   first source word address       [ADDR_W]
//   dst_adr      in   first destination word address  [ADDR_W]
//   len          in   words to copy, 0..256            [9]
//   busy         out  high in READ or WRITE
//   done         out  one-cycle completion pulse
//   err          out  with done: the copy was aborted
//   words_done   out  words written in the current/last copy [9]
//   mem_adr      out  data memory address             [ADDR_W]
//   mem_datain   out  data memory write data          [DATA_W]
//   mem_w        out  data memory write enable (memory writes on rising edge)
//   mem_r        out  data memory read enable
//   mem_dataout  in   data memory read data, combinational while mem_r=1
//   dbg_state    out  current FSM state encoding (IDLE=0 READ=1 WRITE=2 DONE=3)
//
// Handshake: start is a level request without a ready; it is consumed on the
// first rising edge seen in IDLE and ignored everywhere else. The caller
// observes acceptance through busy (or done for len=0) and completion through
// the single-cycle done pulse; there is no back-pressure on the memory side.
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_adr,
  input  logic [ADDR_W-1:0] dst_adr,
  input  logic [8:0]        len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [8:0]        words_done,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [8:0]        len_q;
  logic [8:0]        idx;
  logic [DATA_W-1:0] buf_q;
  logic              err_q;
  logic              last_word;
  logic [ADDR_W-1:0] idx_ext;

  // idx never exceeds 255 here, so idx+1 fits in 9 bits even for len=256.
  assign last_word = ((idx + 9'd1) == len_q);
  assign idx_ext   = ADDR_W'(idx);
  assign dbg_state = state;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      words_done <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_q      <= src_adr;
            dst_q      <= dst_adr;
            len_q      <= len;
            idx        <= '0;
            words_done <= '0;
            err_q      <= 1'b0;
          end
        end
        READ: begin
          buf_q <= mem_dataout;
          if (abort) err_q <= 1'b1;
        end
        WRITE: begin
          idx        <= idx + 9'd1;
          words_done <= words_done + 9'd1;
          // An abort landing on the final write still counts as a clean finish.
          if (abort && !last_word) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == 9'd0) ? DONE : READ;
      READ:    state_nxt = abort ? DONE : WRITE;
      WRITE:   state_nxt = (last_word || abort) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from the state register only, so the asynchronous reset
  // drops mem_w/mem_r immediately without waiting for a clock edge.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_adr    = '0;
    mem_datain = '0;
    case (state)
      READ: begin
        busy    = 1'b1;
        mem_r   = 1'b1;
        mem_adr = src_q + idx_ext;
      end
      WRITE: begin
        busy       = 1'b1;
        mem_w      = 1'b1;
        mem_adr    = dst_q + idx_ext;
        mem_datain = buf_q;
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule
